sum_round_sequencer: RTL and testbench
======================================

Name: sum_round_sequencer

Overview:
Sequences one game of the scrambled-number sum game once the access-control block has unlocked the board. It requests operand pairs from the scrambler/generator, strobes them into the two display load registers, collects the player's sum guess, checks it, and keeps score, tries and round count. It sits between the access-control block and the operand generator/display datapath and is the only block that drives the display load strobes.

Parameters:
DATA_W, 4, operand width; the sum and guess are DATA_W+1 bits.
MAX_TRIES, 3, guesses allowed per round (1..3).
ROUNDS, 4, rounds per game (1..15).
TIMEOUT, 200, cycles allowed in WAIT_GUESS before the round is failed (>=2).
SCORE_W, 8, score counter width; score saturates.

Ports:
Clk  in  1  system clock
Rst  in  1  synchronous reset, active-high
access_ok  in  1  level; high means access-control has granted access
start  in  1  single-cycle pulse (debounced push) that starts a game
gen_req  out  1  single-cycle request for a new operand pair
gen_ack  in  1  generator pair valid; rnd_a/rnd_b are sampled on this cycle
rnd_a  in  DATA_W  operand A from the generator
rnd_b  in  DATA_W  operand B from the generator
guess  in  DATA_W+1  player sum
guess_vld  in  1  single-cycle pulse marking guess valid
ld_a  out  1  display load strobe for operand A
ld_b  out  1  display load strobe for operand B
disp_a  out  DATA_W  latched operand A
disp_b  out  DATA_W  latched operand B
correct  out  1  one-cycle pulse on a correct guess
wrong  out  1  one-cycle pulse on a wrong guess or a timeout
score  out  SCORE_W  correct-round count, saturating
tries_left  out  2  guesses remaining in the current round
round_num  out  4  current round, 1-based; 0 when idle
busy  out  1  high in every state except IDLE and DONE
game_over  out  1  high in DONE

Behaviour:
- Reset (synchronous, Rst high at a rising edge):
  - state to IDLE.
  - All outputs are 0, including score, disp_a/b, round_num and tries_left.
- Reset mid-game aborts the game immediately, with no correct or wrong pulse.
- FSM states: IDLE, REQ, WAIT_GEN, LOAD_A, LOAD_B, WAIT_GUESS, CHECK, NEXT, DONE.
- IDLE:
  - On start & access_ok: go to REQ, clear score, set round_num=1.
  - start without access_ok is ignored.
- REQ: gen_req=1 for exactly one cycle, then go to WAIT_GEN.
- WAIT_GEN:
  - On gen_ack, latch rnd_a/rnd_b into internal operand registers, go to LOAD_A.
  - No timeout; waits indefinitely.
- LOAD_A: ld_a=1 for one cycle; disp_a updates on this edge. Go to LOAD_B.
- LOAD_B:
  - ld_b=1 for one cycle; disp_b updates.
  - tries_left=MAX_TRIES, timeout counter cleared. Go to WAIT_GUESS.
  - ld_a and ld_b are never high together.
- WAIT_GUESS:
  - On guess_vld, register guess and go to CHECK.
  - The timeout counter increments each cycle. When it reaches TIMEOUT-1 with no guess_vld: wrong=1, tries_left=0, go to NEXT.
  - If guess_vld and timeout coincide, the guess wins.
  - guess_vld in any other state is ignored.
- CHECK (one cycle): compare the registered guess with the zero-extended disp_a+disp_b, computed at DATA_W+1 bits with no overflow.
  - Equal: correct=1, score+1 (saturating at 2^SCORE_W-1), go to NEXT.
  - Not equal: wrong=1, tries_left-1.
    - If the result is 0, go to NEXT.
    - Otherwise return to WAIT_GUESS with the timeout counter cleared; operands and display stay unchanged.
- NEXT:
  - If round_num==ROUNDS, go to DONE.
  - Otherwise round_num+1 and go to REQ.
- DONE:
  - game_over=1; score and round_num hold.
  - start & access_ok begins a new game, entering REQ with score cleared.
- access_ok dropping in any busy state is an abort: go to IDLE next cycle.
  - round_num=0, tries_left=0.
  - score, disp_a and disp_b hold.
  - No correct or wrong pulse.
- At most one of correct and wrong is high in any cycle.
- Latency:
  - start to gen_req: 1 cycle.
  - gen_ack to ld_a: 1 cycle.
  - guess_vld to correct/wrong: 2 cycles.

Test Plan:
- Reset and lock: Rst=1 for 2 cycles, then start=1 with access_ok=0 -> all outputs 0, state stays IDLE, gen_req never asserts.
- Correct round: access_ok=1, start, gen_ack with a=7, b=9, guess=16 -> gen_req one cycle after start; ld_a then ld_b on consecutive cycles; disp_a=7, disp_b=9; correct 2 cycles after guess_vld; score=1; round_num=2; new gen_req.
- Exhausted tries: a=15, b=15; guesses 29, 31, 0 -> three wrong pulses; tries_left 3→2→1→0; score unchanged; advances to round 2.
- Timeout and collision: no guess for TIMEOUT cycles -> wrong pulse, round advances. In a second run, guess_vld lands on the timeout cycle -> guess is checked and no timeout wrong pulse occurs.
- Full game: ROUNDS=4, all guesses correct -> game_over=1, score=4, round_num=4; start in DONE restarts with score=0.
- Abort: access_ok drops in WAIT_GUESS -> IDLE next cycle, busy=0, no correct/wrong pulse. Rst in LOAD_A -> ld_a low next cycle and all outputs 0.

Source files
------------

// File: rtl/sum_round_sequencer.sv
// sum_round_sequencer: runs one game of the scrambled-number sum game.
// Ports: Clk/Rst, access_ok, start, gen_req/gen_ack/rnd_a/rnd_b (generator),
//   guess/guess_vld (player), ld_a/ld_b/disp_a/disp_b (display),
//   correct/wrong pulses, score, tries_left, round_num, busy, game_over.
module sum_round_sequencer #(
  parameter int DATA_W    = 4,
  parameter int MAX_TRIES = 3,
  parameter int ROUNDS    = 4,
  parameter int TIMEOUT   = 200,
  parameter int SCORE_W   = 8
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               access_ok,
  input  logic               start,
  output logic               gen_req,
  input  logic               gen_ack,
  input  logic [DATA_W-1:0]  rnd_a,
  input  logic [DATA_W-1:0]  rnd_b,
  input  logic [DATA_W:0]    guess,
  input  logic               guess_vld,
  output logic               ld_a,
  output logic               ld_b,
  output logic [DATA_W-1:0]  disp_a,
  output logic [DATA_W-1:0]  disp_b,
  output logic               correct,
  output logic               wrong,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         tries_left,
  output logic [3:0]         round_num,
  output logic               busy,
  output logic               game_over
);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_WAIT_GEN, S_LOAD_A, S_LOAD_B,
    S_WAIT_GUESS, S_CHECK, S_NEXT, S_DONE
  } state_t;

  localparam int TO_W = $clog2(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [3:0] RN_LAST = 4'(ROUNDS);
  localparam logic [1:0] TRIES_INIT = 2'(MAX_TRIES);

  state_t r_state;
  state_t w_next;

  logic [DATA_W-1:0]  r_op_a;
  logic [DATA_W-1:0]  r_op_b;
  logic [DATA_W-1:0]  r_disp_a;
  logic [DATA_W-1:0]  r_disp_b;
  logic [DATA_W:0]    r_guess;
  logic [DATA_W:0]    w_sum;
  logic [TO_W-1:0]    r_tcnt;
  logic [SCORE_W-1:0] r_score;
  logic [1:0]         r_tries;
  logic [1:0]         w_tries_dec;
  logic [3:0]         r_round;
  logic               r_correct;
  logic               r_wrong;
  logic               w_go;
  logic               w_abort;
  logic               w_timeout;
  logic               w_match;
  logic               w_last_round;

  assign w_go         = start & access_ok;
  assign w_abort      = busy & ~access_ok;
  assign w_sum        = {1'b0, r_disp_a} + {1'b0, r_disp_b};
  assign w_match      = (r_guess == w_sum);
  assign w_tries_dec  = r_tries - 2'd1;
  assign w_last_round = (r_round == RN_LAST);
  // a guess arriving on the final timeout cycle takes priority
  assign w_timeout    = ~guess_vld & (r_tcnt == TO_LAST);

  assign disp_a     = r_disp_a;
  assign disp_b     = r_disp_b;
  assign correct    = r_correct;
  assign wrong      = r_wrong;
  assign score      = r_score;
  assign tries_left = r_tries;
  assign round_num  = r_round;

  always_ff @(posedge Clk) begin
    if (Rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:       if (w_go) w_next = S_REQ;
        S_REQ:        w_next = S_WAIT_GEN;
        S_WAIT_GEN:   if (gen_ack) w_next = S_LOAD_A;
        S_LOAD_A:     w_next = S_LOAD_B;
        S_LOAD_B:     w_next = S_WAIT_GUESS;
        S_WAIT_GUESS: begin
          if (guess_vld)      w_next = S_CHECK;
          else if (w_timeout) w_next = S_NEXT;
        end
        S_CHECK: begin
          if (w_match || w_tries_dec == 2'd0) w_next = S_NEXT;
          else                                w_next = S_WAIT_GUESS;
        end
        S_NEXT:       w_next = w_last_round ? S_DONE : S_REQ;
        S_DONE:       if (w_go) w_next = S_REQ;
        default:      w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    gen_req   = 1'b0;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    busy      = 1'b1;
    game_over = 1'b0;
    unique case (r_state)
      S_IDLE:   busy = 1'b0;
      S_REQ:    gen_req = 1'b1;
      S_LOAD_A: ld_a = 1'b1;
      S_LOAD_B: ld_b = 1'b1;
      S_DONE: begin
        busy      = 1'b0;
        game_over = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_disp_a  <= '0;
      r_disp_b  <= '0;
      r_guess   <= '0;
      r_tcnt    <= '0;
      r_score   <= '0;
      r_tries   <= '0;
      r_round   <= '0;
      r_correct <= 1'b0;
      r_wrong   <= 1'b0;
    end else begin
      r_correct <= 1'b0;
      r_wrong   <= 1'b0;
      if (w_abort) begin
        r_round <= '0;
        r_tries <= '0;
      end else begin
        unique case (r_state)
          S_IDLE, S_DONE: begin
            if (w_go) begin
              r_score <= '0;
              r_round <= 4'd1;
            end
          end
          S_WAIT_GEN: begin
            if (gen_ack) begin
              r_op_a <= rnd_a;
              r_op_b <= rnd_b;
            end
          end
          S_LOAD_A: r_disp_a <= r_op_a;
          S_LOAD_B: begin
            r_disp_b <= r_op_b;
            r_tries  <= TRIES_INIT;
            r_tcnt   <= '0;
          end
          S_WAIT_GUESS: begin
            if (guess_vld) begin
              r_guess <= guess;
            end else if (w_timeout) begin
              r_wrong <= 1'b1;
              r_tries <= '0;
            end else begin
              r_tcnt <= r_tcnt + TO_W'(1);
            end
          end
          S_CHECK: begin
            if (w_match) begin
              r_correct <= 1'b1;
              if (r_score != '1) r_score <= r_score + SCORE_W'(1);
            end else begin
              r_wrong <= 1'b1;
              r_tries <= w_tries_dec;
              r_tcnt  <= '0;
            end
          end
          S_NEXT: begin
            if (!w_last_round) r_round <= r_round + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sum_round_sequencer.sv
// tb_sum_round_sequencer: directed + randomized game play checked
// against a round-level model of score, tries and round count.
module tb_sum_round_sequencer;

  localparam int DATA_W    = 4;
  localparam int MAX_TRIES = 3;
  localparam int ROUNDS    = 4;
  localparam int TIMEOUT   = 200;
  localparam int SCORE_W   = 8;

  logic              Clk = 1'b0;
  logic              Rst = 1'b0;
  logic              access_ok = 1'b0;
  logic              start = 1'b0;
  logic              gen_ack = 1'b0;
  logic [DATA_W-1:0] rnd_a = '0;
  logic [DATA_W-1:0] rnd_b = '0;
  logic [DATA_W:0]   guess = '0;
  logic              guess_vld = 1'b0;

  logic               gen_req;
  logic               ld_a;
  logic               ld_b;
  logic [DATA_W-1:0]  disp_a;
  logic [DATA_W-1:0]  disp_b;
  logic               correct;
  logic               wrong;
  logic [SCORE_W-1:0] score;
  logic [1:0]         tries_left;
  logic [3:0]         round_num;
  logic               busy;
  logic               game_over;

  int checks = 0;
  int failures = 0;
  int exp_score;
  int exp_round;
  int exp_tries;
  int cur_a;
  int cur_b;

  sum_round_sequencer #(
    .DATA_W(DATA_W), .MAX_TRIES(MAX_TRIES), .ROUNDS(ROUNDS),
    .TIMEOUT(TIMEOUT), .SCORE_W(SCORE_W)
  ) dut (
    .Clk(Clk), .Rst(Rst), .access_ok(access_ok), .start(start),
    .gen_req(gen_req), .gen_ack(gen_ack), .rnd_a(rnd_a),
    .rnd_b(rnd_b), .guess(guess), .guess_vld(guess_vld),
    .ld_a(ld_a), .ld_b(ld_b), .disp_a(disp_a), .disp_b(disp_b),
    .correct(correct), .wrong(wrong), .score(score),
    .tries_left(tries_left), .round_num(round_num),
    .busy(busy), .game_over(game_over)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({gen_req, ld_a, ld_b, disp_a, disp_b, correct, wrong,
                score, tries_left, round_num, busy, game_over});
  endfunction

  // current cycle: IDLE or DONE
  task automatic start_game();
    access_ok = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    exp_score = 0;
    exp_round = 1;
    chk("start_gen_req", 32'(gen_req), 1);
    chk("start_round", 32'(round_num), 1);
    chk("start_score", 32'(score), 0);
    chk("start_busy", 32'(busy), 1);
  endtask

  // current cycle: REQ; returns in the first WAIT_GUESS cycle
  task automatic serve(input int a, input int b);
    int wait_n;
    wait_n = $urandom_range(0, 3);
    step();
    chk("gen_req_one_cycle", 32'(gen_req), 0);
    for (int i = 0; i < wait_n; i++) begin
      guess = 5'($urandom);
      guess_vld = 1'b1;
      step();
      guess_vld = 1'b0;
    end
    chk("wait_gen_no_ld", 32'({ld_a, ld_b}), 0);
    gen_ack = 1'b1;
    rnd_a = 4'(a);
    rnd_b = 4'(b);
    step();
    gen_ack = 1'b0;
    rnd_a = 4'($urandom);
    rnd_b = 4'($urandom);
    chk("ld_a_phase", 32'({ld_a, ld_b}), 32'b10);
    step();
    chk("ld_b_phase", 32'({ld_a, ld_b}), 32'b01);
    chk("disp_a", 32'(disp_a), 32'(a));
    step();
    chk("disp_b", 32'(disp_b), 32'(b));
    chk("tries_init", 32'(tries_left), MAX_TRIES);
    chk("ld_idle", 32'({ld_a, ld_b}), 0);
    cur_a = a;
    cur_b = b;
    exp_tries = MAX_TRIES;
  endtask

  // current cycle: WAIT_GUESS; returns two cycles later
  task automatic do_guess(input int g, output bit over);
    bit ok;
    ok = (g == cur_a + cur_b);
    guess = 5'(g);
    guess_vld = 1'b1;
    step();
    guess_vld = 1'b0;
    chk("check_no_pulse", 32'({correct, wrong}), 0);
    step();
    chk("correct_pulse", 32'(correct), 32'(ok));
    chk("wrong_pulse", 32'(wrong), 32'(!ok));
    if (ok) begin
      exp_score = (exp_score < 255) ? exp_score + 1 : 255;
      over = 1'b1;
    end else begin
      exp_tries--;
      over = (exp_tries == 0);
    end
    chk("score", 32'(score), 32'(exp_score));
    chk("tries_left", 32'(tries_left), 32'(exp_tries));
  endtask

  // current cycle: NEXT
  task automatic end_round();
    step();
    chk("pulse_cleared", 32'({correct, wrong}), 0);
    if (exp_round == ROUNDS) begin
      chk("game_over", 32'({game_over, busy}), 32'b10);
      chk("final_round", 32'(round_num), ROUNDS);
      chk("final_score", 32'(score), 32'(exp_score));
    end else begin
      exp_round++;
      chk("next_gen_req", 32'(gen_req), 1);
      chk("next_round", 32'(round_num), 32'(exp_round));
    end
  endtask

  task automatic play_round(input bit all_correct);
    int a;
    int b;
    int g;
    bit over;
    a = $urandom_range(0, 15);
    b = $urandom_range(0, 15);
    over = 1'b0;
    serve(a, b);
    while (!over) begin
      if (all_correct || $urandom_range(0, 1) == 1) g = a + b;
      else g = (a + b + $urandom_range(1, 31)) % 32;
      do_guess(g, over);
    end
    end_round();
  endtask

  initial begin
    bit over;
    bit seen;
    int a;
    int b;

    Rst = 1'b1;
    step();
    step();
    Rst = 1'b0;
    chk("reset_outputs", all_outs(), 0);

    access_ok = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (gen_req || busy) seen = 1'b1;
      step();
    end
    chk("locked_no_req", 32'(seen), 0);
    chk("locked_outputs", all_outs(), 0);

    start_game();
    serve(7, 9);
    do_guess(16, over);
    chk("r1_over", 32'(over), 1);
    end_round();
    chk("r1_score", 32'(score), 1);

    serve(15, 15);
    do_guess(29, over);
    do_guess(31, over);
    do_guess(0, over);
    chk("r2_exhausted", 32'(over), 1);
    end_round();

    a = $urandom_range(0, 15);
    b = $urandom_range(0, 15);
    serve(a, b);
    seen = 1'b0;
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      step();
      if (correct || wrong || !busy) seen = 1'b1;
    end
    chk("timeout_early", 32'(seen), 0);
    step();
    chk("timeout_wrong", 32'({correct, wrong}), 32'b01);
    chk("timeout_tries", 32'(tries_left), 0);
    exp_tries = 0;
    end_round();

    a = $urandom_range(0, 15);
    b = $urandom_range(0, 15);
    serve(a, b);
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    do_guess(a + b, over);
    end_round();
    chk("game1_score", 32'(score), 2);

    start_game();
    for (int r = 0; r < ROUNDS; r++) play_round(1'b1);
    chk("game2_score", 32'(score), 4);

    start_game();
    for (int r = 0; r < ROUNDS; r++) play_round(1'b0);

    start_game();
    serve(3, 5);
    access_ok = 1'b0;
    step();
    chk("abort_busy", 32'({busy, game_over}), 0);
    chk("abort_round", 32'(round_num), 0);
    chk("abort_tries", 32'(tries_left), 0);
    chk("abort_pulse", 32'({correct, wrong}), 0);
    chk("abort_disp", 32'({disp_a, disp_b}), 32'({4'd3, 4'd5}));
    chk("abort_score", 32'(score), 0);

    start_game();
    serve(6, 2);
    guess = 5'd8;
    guess_vld = 1'b1;
    step();
    guess_vld = 1'b0;
    access_ok = 1'b0;
    step();
    chk("abort_check_pulse", 32'({correct, wrong}), 0);
    chk("abort_check_score", 32'(score), 0);
    chk("abort_check_busy", 32'(busy), 0);

    start_game();
    step();
    gen_ack = 1'b1;
    rnd_a = 4'd11;
    rnd_b = 4'd4;
    step();
    gen_ack = 1'b0;
    chk("pre_rst_ld_a", 32'(ld_a), 1);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    chk("rst_load_a_outputs", all_outs(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
